// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: core-side enables and handshake plus the trap
// request, cause and pending vector going back to the core.
interface int_ctrl_if;
    localparam int unsigned N_IRQ   = 4;
    localparam int unsigned CAUSE_W = 2;

    logic [N_IRQ-1:0]   irq_in;
    logic [N_IRQ-1:0]   mie;
    logic               gie;
    logic               trap_ack;
    logic               mret;
    logic               trap_req;
    logic [CAUSE_W-1:0] trap_cause;
    logic               in_service;
    logic [N_IRQ-1:0]   mip;

    // Core / stimulus side
    modport master (
        output irq_in, mie, gie, trap_ack, mret,
        input  trap_req, trap_cause, in_service, mip
    );

    // Controller side
    modport slave (
        input  irq_in, mie, gie, trap_ack, mret,
        output trap_req, trap_cause, in_service, mip
    );
endinterface

// File: rtl/int_ctrl.sv
// Four-line interrupt controller: per-line level/edge pending capture, fixed
// priority (line 0 highest), single outstanding trap with no nesting.
module int_ctrl #(
    parameter logic [3:0] EDGE_MASK = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    int_ctrl_if.slave   bus
);
    localparam int unsigned N_IRQ   = 4;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [N_IRQ-1:0]   irq_q;
    logic [N_IRQ-1:0]   mip_q;
    logic               trap_req_q;
    logic [CAUSE_W-1:0] trap_cause_q;
    logic               in_service_q;

    logic [N_IRQ-1:0]   eligible_c;
    logic [N_IRQ-1:0]   edge_set_c;
    logic [N_IRQ-1:0]   ack_clr_c;
    logic [N_IRQ-1:0]   mip_nxt_c;
    logic [CAUSE_W-1:0] lowest_c;

    // Lowest set index wins; zero when nothing is set.
    function automatic logic [CAUSE_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
        lowest_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = CAUSE_W'(i);
        end
    endfunction

    // Pending capture: level lines follow the input, edge lines are sticky
    // until acknowledged, and a new edge beats a same-cycle acknowledge.
    always_comb begin
        eligible_c = mip_q & bus.mie & {N_IRQ{bus.gie}};
        edge_set_c = bus.irq_in & ~irq_q;
        ack_clr_c  = '0;
        if (state == REQ && bus.trap_ack) begin
            ack_clr_c = N_IRQ'(1) << trap_cause_q;
        end
        mip_nxt_c  = (~EDGE_MASK & bus.irq_in)
                   | ( EDGE_MASK & (edge_set_c | (mip_q & ~ack_clr_c)));
        lowest_c   = lowest_idx(eligible_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            irq_q        <= '0;
            mip_q        <= '0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= '0;
            in_service_q <= 1'b0;
        end else begin
            irq_q <= bus.irq_in;
            mip_q <= mip_nxt_c;
            unique case (state)
                IDLE: begin
                    if (|eligible_c) begin
                        state        <= REQ;
                        trap_req_q   <= 1'b1;
                        trap_cause_q <= lowest_c;
                    end
                end
                REQ: begin
                    // Acknowledge beats withdraw; cause stays frozen meanwhile.
                    if (bus.trap_ack) begin
                        state        <= SERVICE;
                        trap_req_q   <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!eligible_c[trap_cause_q]) begin
                        state        <= IDLE;
                        trap_req_q   <= 1'b0;
                        trap_cause_q <= '0;
                    end
                end
                SERVICE: begin
                    if (bus.mret) begin
                        state        <= IDLE;
                        in_service_q <= 1'b0;
                        trap_cause_q <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    trap_req_q   <= 1'b0;
                    trap_cause_q <= '0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trap_req   = trap_req_q;
    assign bus.trap_cause = trap_cause_q;
    assign bus.in_service = in_service_q;
    assign bus.mip        = mip_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: one level-only instance and one with line 0
// in edge mode, sharing clock and reset.
module tb_int_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    int_ctrl_if lvl_if ();
    int_ctrl_if edg_if ();

    int_ctrl #(.EDGE_MASK(4'b0000)) u_lvl (.clk(clk), .rst(rst), .bus(lvl_if.slave));
    int_ctrl #(.EDGE_MASK(4'b0001)) u_edg (.clk(clk), .rst(rst), .bus(edg_if.slave));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lvl(input string tag, input logic req, input logic [1:0] cause,
                           input logic svc, input logic [3:0] mip);
        check({tag, ".req"},   8'(lvl_if.trap_req),   8'(req));
        check({tag, ".cause"}, 8'(lvl_if.trap_cause), 8'(cause));
        check({tag, ".svc"},   8'(lvl_if.in_service), 8'(svc));
        check({tag, ".mip"},   8'(lvl_if.mip),        8'(mip));
    endtask

    task automatic chk_edg(input string tag, input logic req, input logic [1:0] cause,
                           input logic svc, input logic [3:0] mip);
        check({tag, ".req"},   8'(edg_if.trap_req),   8'(req));
        check({tag, ".cause"}, 8'(edg_if.trap_cause), 8'(cause));
        check({tag, ".svc"},   8'(edg_if.in_service), 8'(svc));
        check({tag, ".mip"},   8'(edg_if.mip),        8'(mip));
    endtask

    initial begin
        lvl_if.irq_in = '0; lvl_if.mie = 4'hF; lvl_if.gie = 1'b1;
        lvl_if.trap_ack = 1'b0; lvl_if.mret = 1'b0;
        edg_if.irq_in = '0; edg_if.mie = 4'hF; edg_if.gie = 1'b0;
        edg_if.trap_ack = 1'b0; edg_if.mret = 1'b0;
        rst = 1'b1;
        step(); step();
        chk_lvl("rst_lvl", 1'b0, 2'd0, 1'b0, 4'b0000);
        chk_edg("rst_edg", 1'b0, 2'd0, 1'b0, 4'b0000);
        rst = 1'b0;

        // Level request on line 2, then ack and return.
        lvl_if.irq_in = 4'b0100;
        step(); chk_lvl("lvl_mip",  1'b0, 2'd0, 1'b0, 4'b0100);
        step(); chk_lvl("lvl_req",  1'b1, 2'd2, 1'b0, 4'b0100);
        lvl_if.trap_ack = 1'b1;
        step(); chk_lvl("lvl_ack",  1'b0, 2'd2, 1'b1, 4'b0100);
        lvl_if.trap_ack = 1'b0; lvl_if.irq_in = 4'b0000; lvl_if.mret = 1'b1;
        step(); chk_lvl("lvl_mret", 1'b0, 2'd0, 1'b0, 4'b0000);
        lvl_if.mret = 1'b0;

        // Stray ack/mret in IDLE do nothing.
        lvl_if.trap_ack = 1'b1; lvl_if.mret = 1'b1;
        step(); chk_lvl("stray", 1'b0, 2'd0, 1'b0, 4'b0000);
        lvl_if.trap_ack = 1'b0; lvl_if.mret = 1'b0;

        // Cause stays latched when a higher-priority line arrives in REQ.
        lvl_if.irq_in = 4'b1000;
        step(); step(); chk_lvl("pri_req3", 1'b1, 2'd3, 1'b0, 4'b1000);
        lvl_if.irq_in = 4'b1001;
        step(); chk_lvl("pri_hold", 1'b1, 2'd3, 1'b0, 4'b1001);
        lvl_if.trap_ack = 1'b1;
        step(); chk_lvl("pri_svc",  1'b0, 2'd3, 1'b1, 4'b1001);
        lvl_if.trap_ack = 1'b0; lvl_if.irq_in = 4'b0001;
        step(); chk_lvl("pri_nonest", 1'b0, 2'd3, 1'b1, 4'b0001);
        lvl_if.mret = 1'b1;
        step(); chk_lvl("pri_idle", 1'b0, 2'd0, 1'b0, 4'b0001);
        lvl_if.mret = 1'b0;
        step(); chk_lvl("pri_req0", 1'b1, 2'd0, 1'b0, 4'b0001);
        lvl_if.trap_ack = 1'b1;
        step(); lvl_if.trap_ack = 1'b0; lvl_if.irq_in = 4'b0000; lvl_if.mret = 1'b1;
        step(); lvl_if.mret = 1'b0;
        chk_lvl("pri_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Withdraw when the enable drops, then ack beating withdraw.
        lvl_if.irq_in = 4'b0010;
        step(); step(); chk_lvl("wd_req", 1'b1, 2'd1, 1'b0, 4'b0010);
        lvl_if.mie = 4'b1101;
        step(); chk_lvl("wd_drop", 1'b0, 2'd0, 1'b0, 4'b0010);
        lvl_if.mie = 4'hF;
        step(); chk_lvl("wd_rereq", 1'b1, 2'd1, 1'b0, 4'b0010);
        lvl_if.mie = 4'b1101; lvl_if.trap_ack = 1'b1;
        step(); chk_lvl("wd_ackwin", 1'b0, 2'd1, 1'b1, 4'b0010);
        lvl_if.mie = 4'hF; lvl_if.trap_ack = 1'b0; lvl_if.irq_in = 4'b0000; lvl_if.mret = 1'b1;
        step(); lvl_if.mret = 1'b0;
        chk_lvl("wd_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Edge line 0: pulse latched while gie=0.
        edg_if.irq_in = 4'b0001;
        step(); edg_if.irq_in = 4'b0000;
        step(); chk_edg("edg_sticky", 1'b0, 2'd0, 1'b0, 4'b0001);
        edg_if.gie = 1'b1;
        step(); chk_edg("edg_req", 1'b1, 2'd0, 1'b0, 4'b0001);
        edg_if.trap_ack = 1'b1;
        step(); chk_edg("edg_clr", 1'b0, 2'd0, 1'b1, 4'b0000);
        edg_if.trap_ack = 1'b0; edg_if.mret = 1'b1;
        step(); edg_if.mret = 1'b0;
        chk_edg("edg_idle", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Second pulse coincident with ack: set wins.
        edg_if.irq_in = 4'b0001;
        step(); edg_if.irq_in = 4'b0000;
        step(); chk_edg("edg_req2", 1'b1, 2'd0, 1'b0, 4'b0001);
        edg_if.irq_in = 4'b0001; edg_if.trap_ack = 1'b1;
        step(); chk_edg("edg_setwin", 1'b0, 2'd0, 1'b1, 4'b0001);
        edg_if.trap_ack = 1'b0; edg_if.irq_in = 4'b0010;
        step(); chk_edg("edg_svc_mip", 1'b0, 2'd0, 1'b1, 4'b0011);

        // Reset while in SERVICE with pending lines.
        rst = 1'b1;
        step(); chk_edg("rst_svc", 1'b0, 2'd0, 1'b0, 4'b0000);
        rst = 1'b0; edg_if.irq_in = 4'b0000;
        step(); chk_edg("rst_after1", 1'b0, 2'd0, 1'b0, 4'b0000);
        step(); chk_edg("rst_after2", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Edge line held high across reset registers once released.
        edg_if.irq_in = 4'b0001; rst = 1'b1;
        step(); chk_edg("hold_rst", 1'b0, 2'd0, 1'b0, 4'b0000);
        rst = 1'b0;
        step(); chk_edg("hold_edge", 1'b0, 2'd0, 1'b0, 4'b0001);
        step(); chk_edg("hold_req",  1'b1, 2'd0, 1'b0, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
